// File: rtl/jpeg_idct_pkg.sv
// Shared constants and helpers for the islow 8-point IDCT datapath.
// Constants are round(x * 2^13), matching libjpeg jidctint.
package jpeg_idct_pkg;

   localparam int IDCT_CONST_BITS = 13;

   localparam int FIX_0_298631336 = 2446;
   localparam int FIX_0_390180644 = 3196;
   localparam int FIX_0_541196100 = 4433;
   localparam int FIX_0_765366865 = 6270;
   localparam int FIX_0_899976223 = 7373;
   localparam int FIX_1_175875602 = 9633;
   localparam int FIX_1_501321110 = 12299;
   localparam int FIX_1_847759065 = 15137;
   localparam int FIX_1_961570560 = 16069;
   localparam int FIX_2_053119869 = 16819;
   localparam int FIX_2_562915447 = 20995;
   localparam int FIX_3_072711026 = 25172;

   // Clamp a signed value into the range of a signed integer of the given width.
   function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (value > hi) return hi;
      if (value < lo) return lo;
      return value;
   endfunction

endpackage

// File: rtl/idct_pipe_slice.sv
// One pipeline register slice {valid, data}; stalls hold contents, bubbles leave data untouched.
// Latency 1 cycle; advances only when ld_i is high.
module idct_pipe_slice #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_i,
   input  logic             v_i,
   input  logic [WIDTH-1:0] d_i,
   output logic             v_o,
   output logic [WIDTH-1:0] d_o
);

   logic             v_q;
   logic [WIDTH-1:0] d_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= 1'b0;
         d_q <= '0;
      end else if (ld_i) begin
         v_q <= v_i;
         if (v_i) d_q <= d_i;
      end
   end

   assign v_o = v_q;
   assign d_o = d_q;

endmodule

// File: rtl/loeffler_idct_1d.sv
// 8-point 1-D islow IDCT, 4 register stages, one vector per cycle, 4-cycle latency.
// Backpressure: each stage loads when empty or when the stage after it loads, so bubbles collapse.
module loeffler_idct_1d
   import jpeg_idct_pkg::*;
#(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 16,
   parameter int OUT_SHIFT = 11
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   valid_in,
   output logic                   ready_out,
   input  logic [8*IN_WIDTH-1:0]  idct_in,
   output logic [8*OUT_WIDTH-1:0] idct_out,
   output logic                   valid_out,
   input  logic                   ready_in
);

   localparam int W = IN_WIDTH + 16;
   typedef logic signed [W-1:0] wd_t;

   localparam wd_t RND    = wd_t'(64'sd1 <<< (OUT_SHIFT - 1));
   localparam wd_t K_0298 = wd_t'(FIX_0_298631336);
   localparam wd_t K_0390 = wd_t'(FIX_0_390180644);
   localparam wd_t K_0541 = wd_t'(FIX_0_541196100);
   localparam wd_t K_0765 = wd_t'(FIX_0_765366865);
   localparam wd_t K_0899 = wd_t'(FIX_0_899976223);
   localparam wd_t K_1175 = wd_t'(FIX_1_175875602);
   localparam wd_t K_1501 = wd_t'(FIX_1_501321110);
   localparam wd_t K_1847 = wd_t'(FIX_1_847759065);
   localparam wd_t K_1961 = wd_t'(FIX_1_961570560);
   localparam wd_t K_2053 = wd_t'(FIX_2_053119869);
   localparam wd_t K_2562 = wd_t'(FIX_2_562915447);
   localparam wd_t K_3072 = wd_t'(FIX_3_072711026);

   logic ld1, ld2, ld3, ld4;
   logic v1, v2, v3, v4;
   logic [8*W-1:0]         s1_d, s1_q, s3_d, s3_q;
   logic [12*W-1:0]        s2_d, s2_q;
   logic [8*OUT_WIDTH-1:0] s4_d, s4_q;

   wd_t x_in [8];
   wd_t st1 [8];
   wd_t r1 [8];
   wd_t st2 [12];
   wd_t r2 [12];
   wd_t st3 [8];
   wd_t r3 [8];
   wd_t y [8];
   wd_t ez1, oz1, oz2, oz3, oz4, oz5;

   assign ld4       = !v4 || ready_in;
   assign ld3       = !v3 || ld4;
   assign ld2       = !v2 || ld3;
   assign ld1       = !v1 || ld2;
   assign ready_out = ld1;
   assign valid_out = v4;
   assign idct_out  = s4_q;

   // S1 layout: t0, t1, t2, t3, X1, X3, X5, X7
   always_comb begin
      s1_d = '0;
      for (int k = 0; k < 8; k++) x_in[k] = wd_t'(signed'(idct_in[k*IN_WIDTH +: IN_WIDTH]));
      ez1    = (x_in[2] + x_in[6]) * K_0541;
      st1[0] = (x_in[0] + x_in[4]) <<< IDCT_CONST_BITS;
      st1[1] = (x_in[0] - x_in[4]) <<< IDCT_CONST_BITS;
      st1[2] = ez1 - x_in[6] * K_1847;
      st1[3] = ez1 + x_in[2] * K_0765;
      st1[4] = x_in[1];
      st1[5] = x_in[3];
      st1[6] = x_in[5];
      st1[7] = x_in[7];
      for (int i = 0; i < 8; i++) s1_d[i*W +: W] = st1[i];
   end

   // S2 layout: a10..a13, o0..o3, z1..z4 (z3, z4 already include z5)
   always_comb begin
      s2_d = '0;
      for (int i = 0; i < 8; i++) r1[i] = wd_t'(s1_q[i*W +: W]);
      oz1     = r1[7] + r1[4];
      oz2     = r1[6] + r1[5];
      oz3     = r1[7] + r1[5];
      oz4     = r1[6] + r1[4];
      oz5     = (oz3 + oz4) * K_1175;
      st2[0]  = r1[0] + r1[3];
      st2[1]  = r1[1] + r1[2];
      st2[2]  = r1[1] - r1[2];
      st2[3]  = r1[0] - r1[3];
      st2[4]  = r1[7] * K_0298;
      st2[5]  = r1[6] * K_2053;
      st2[6]  = r1[5] * K_3072;
      st2[7]  = r1[4] * K_1501;
      st2[8]  = oz1 * (-K_0899);
      st2[9]  = oz2 * (-K_2562);
      st2[10] = oz3 * (-K_1961) + oz5;
      st2[11] = oz4 * (-K_0390) + oz5;
      for (int i = 0; i < 12; i++) s2_d[i*W +: W] = st2[i];
   end

   // S3 layout: a10..a13, b0..b3
   always_comb begin
      s3_d = '0;
      for (int i = 0; i < 12; i++) r2[i] = wd_t'(s2_q[i*W +: W]);
      for (int i = 0; i < 4; i++) st3[i] = r2[i];
      st3[4] = r2[4] + r2[8] + r2[10];
      st3[5] = r2[5] + r2[9] + r2[11];
      st3[6] = r2[6] + r2[9] + r2[10];
      st3[7] = r2[7] + r2[8] + r2[11];
      for (int i = 0; i < 8; i++) s3_d[i*W +: W] = st3[i];
   end

   always_comb begin
      s4_d = '0;
      for (int i = 0; i < 8; i++) r3[i] = wd_t'(s3_q[i*W +: W]);
      y[0] = r3[0] + r3[7];
      y[7] = r3[0] - r3[7];
      y[1] = r3[1] + r3[6];
      y[6] = r3[1] - r3[6];
      y[2] = r3[2] + r3[5];
      y[5] = r3[2] - r3[5];
      y[3] = r3[3] + r3[4];
      y[4] = r3[3] - r3[4];
      for (int n = 0; n < 8; n++)
         s4_d[n*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(sat(64'((y[n] + RND) >>> OUT_SHIFT), OUT_WIDTH));
   end

   idct_pipe_slice #(.WIDTH(8*W)) u_s1 (
      .clk(clk), .rst(rst), .ld_i(ld1), .v_i(valid_in), .d_i(s1_d), .v_o(v1), .d_o(s1_q)
   );
   idct_pipe_slice #(.WIDTH(12*W)) u_s2 (
      .clk(clk), .rst(rst), .ld_i(ld2), .v_i(v1), .d_i(s2_d), .v_o(v2), .d_o(s2_q)
   );
   idct_pipe_slice #(.WIDTH(8*W)) u_s3 (
      .clk(clk), .rst(rst), .ld_i(ld3), .v_i(v2), .d_i(s3_d), .v_o(v3), .d_o(s3_q)
   );
   idct_pipe_slice #(.WIDTH(8*OUT_WIDTH)) u_s4 (
      .clk(clk), .rst(rst), .ld_i(ld4), .v_i(v3), .d_i(s4_d), .v_o(v4), .d_o(s4_q)
   );

endmodule

// File: tb/tb_loeffler_idct_1d.sv
// Bench: row (shift 11) and column (shift 18) instances share stimulus and are checked against a libjpeg-style model.
module tb_loeffler_idct_1d;

   localparam int IW = 32;
   localparam int OW = 16;

   logic            clk, rst, valid_in, ready_in;
   logic [8*IW-1:0] idct_in;
   logic            ro_a, ro_b, vo_a, vo_b;
   logic [8*OW-1:0] out_a, out_b;

   loeffler_idct_1d #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .OUT_SHIFT(11)) dut_row (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ro_a), .idct_in(idct_in),
      .idct_out(out_a), .valid_out(vo_a), .ready_in(ready_in)
   );
   loeffler_idct_1d #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .OUT_SHIFT(18)) dut_col (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ro_b), .idct_in(idct_in),
      .idct_out(out_b), .valid_out(vo_b), .ready_in(ready_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [8*OW-1:0] e11;
      logic [8*OW-1:0] e18;
      int              stamp;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int fire_cyc = 0;
   logic last_acc = 1'b0;
   logic out_fire = 1'b0;
   logic obs_ro, obs_vo;
   logic [8*OW-1:0] obs_out_a, obs_out_b;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chkv(input string name, input logic [8*OW-1:0] act, input logic [8*OW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: libjpeg jidctint islow 1-D pass written as straight-line integer arithmetic.
   function automatic logic [8*OW-1:0] ref_idct(input logic [8*IW-1:0] v, input int sh);
      longint x[8];
      longint y[8];
      longint z1, z2, z3, z4, z5, tmp0, tmp1, tmp2, tmp3, tmp10, tmp11, tmp12, tmp13, r;
      logic [8*OW-1:0] res;
      for (int k = 0; k < 8; k++) x[k] = longint'($signed(v[k*IW +: IW]));
      z1    = (x[2] + x[6]) * 4433;
      tmp2  = z1 + x[6] * (-15137);
      tmp3  = z1 + x[2] * 6270;
      tmp0  = (x[0] + x[4]) * 8192;
      tmp1  = (x[0] - x[4]) * 8192;
      tmp10 = tmp0 + tmp3;
      tmp13 = tmp0 - tmp3;
      tmp11 = tmp1 + tmp2;
      tmp12 = tmp1 - tmp2;
      tmp0 = x[7]; tmp1 = x[5]; tmp2 = x[3]; tmp3 = x[1];
      z1 = tmp0 + tmp3; z2 = tmp1 + tmp2; z3 = tmp0 + tmp2; z4 = tmp1 + tmp3;
      z5 = (z3 + z4) * 9633;
      tmp0 = tmp0 * 2446; tmp1 = tmp1 * 16819; tmp2 = tmp2 * 25172; tmp3 = tmp3 * 12299;
      z1 = z1 * (-7373); z2 = z2 * (-20995); z3 = z3 * (-16069); z4 = z4 * (-3196);
      z3 = z3 + z5; z4 = z4 + z5;
      tmp0 = tmp0 + z1 + z3; tmp1 = tmp1 + z2 + z4; tmp2 = tmp2 + z2 + z3; tmp3 = tmp3 + z1 + z4;
      y[0] = tmp10 + tmp3; y[7] = tmp10 - tmp3;
      y[1] = tmp11 + tmp2; y[6] = tmp11 - tmp2;
      y[2] = tmp12 + tmp1; y[5] = tmp12 - tmp1;
      y[3] = tmp13 + tmp0; y[4] = tmp13 - tmp0;
      res = '0;
      for (int n = 0; n < 8; n++) begin
         r = (y[n] + (longint'(1) <<< (sh - 1))) >>> sh;
         if (r > 32767) r = 32767;
         if (r < -32768) r = -32768;
         res[n*OW +: OW] = OW'(r);
      end
      return res;
   endfunction

   function automatic logic [8*IW-1:0] pack_in(input int a[8]);
      logic [8*IW-1:0] v;
      for (int k = 0; k < 8; k++) v[k*IW +: IW] = a[k];
      return v;
   endfunction

   function automatic logic [8*OW-1:0] pack_out(input int a[8]);
      logic [8*OW-1:0] v;
      for (int k = 0; k < 8; k++) v[k*OW +: OW] = OW'(a[k]);
      return v;
   endfunction

   function automatic logic [8*IW-1:0] rnd_vec();
      logic [8*IW-1:0] v;
      int lim;
      int c;
      lim = ($urandom_range(0, 3) == 0) ? (1 << 20) : 2047;
      v = '0;
      for (int k = 0; k < 8; k++) begin
         if ($urandom_range(0, 2) != 0) begin
            c = int'($urandom_range(0, 2 * lim)) - lim;
            v[k*IW +: IW] = c;
         end
      end
      return v;
   endfunction

   // Per-cycle compare: occupancy and age of the oldest vector decide ready_out / valid_out.
   task automatic observe();
      logic exp_ro, exp_vo;
      exp_t e;
      cyc++;
      obs_ro    = ro_a;
      obs_vo    = vo_a;
      obs_out_a = out_a;
      obs_out_b = out_b;
      out_fire  = 1'b0;
      last_acc  = 1'b0;
      if (rst) begin
         q.delete();
         return;
      end
      exp_ro = !(q.size() == 4 && !ready_in);
      exp_vo = 1'b0;
      if (q.size() > 0) exp_vo = (cyc - q[0].stamp >= 4);
      chk("ready_out_row", ro_a, exp_ro);
      chk("ready_out_col", ro_b, exp_ro);
      chk("valid_out_row", vo_a, exp_vo);
      chk("valid_out_col", vo_b, exp_vo);
      if (exp_vo && ready_in) begin
         e = q.pop_front();
         chkv("data_row", out_a, e.e11);
         chkv("data_col", out_b, e.e18);
         out_fire = 1'b1;
         fire_cyc = cyc;
      end
      if (valid_in && exp_ro) begin
         e.e11   = ref_idct(idct_in, 11);
         e.e18   = ref_idct(idct_in, 18);
         e.stamp = cyc;
         q.push_back(e);
         last_acc = 1'b1;
         acc_cyc  = cyc;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [8*IW-1:0] vec);
      int n;
      valid_in = 1'b1;
      idct_in  = vec;
      n = 0;
      do begin
         tick();
         n++;
      end while (!last_acc && n < 50);
      valid_in = 1'b0;
      if (!last_acc) begin
         checks++;
         errors++;
         $display("FAIL send_accept: got no acceptance in 50 cycles, expected ready_out");
      end
   endtask

   task automatic directed(input string name, input logic [8*IW-1:0] vec, input logic [8*OW-1:0] lit);
      int n;
      send(vec);
      n = 0;
      while (!out_fire && n < 20) begin
         tick();
         n++;
      end
      if (!out_fire) begin
         checks++;
         errors++;
         $display("FAIL %s: got no valid_out in 20 cycles, expected one output", name);
      end else begin
         chkv(name, obs_out_a, lit);
         chk({name, "_latency"}, fire_cyc - acc_cyc, 4);
      end
   endtask

   initial begin
      int a[8];
      int e[8];
      int sent, nout, nvo, c;
      logic [8*IW-1:0] bp[10];

      rst = 1'b1; valid_in = 1'b0; ready_in = 1'b1; idct_in = '0;
      @(posedge clk);
      #1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("rst_valid_out", obs_vo, 0);
      chk("rst_ready_out", obs_ro, 1);
      chkv("rst_idct_out_row", obs_out_a, '0);
      chkv("rst_idct_out_col", obs_out_b, '0);

      // DC only
      a = '{64, 0, 0, 0, 0, 0, 0, 0};
      e = '{256, 256, 256, 256, 256, 256, 256, 256};
      chkv("model_dc_row", ref_idct(pack_in(a), 11), pack_out(e));
      directed("dc_row", pack_in(a), pack_out(e));
      e = '{2, 2, 2, 2, 2, 2, 2, 2};
      chkv("model_dc_col", ref_idct(pack_in(a), 18), pack_out(e));

      // X4 only
      a = '{0, 0, 0, 0, 16, 0, 0, 0};
      e = '{64, -64, -64, 64, 64, -64, -64, 64};
      chkv("model_x4_row", ref_idct(pack_in(a), 11), pack_out(e));
      directed("x4_row", pack_in(a), pack_out(e));
      e = '{1, 0, 0, 1, 1, 0, 0, 1};
      chkv("model_x4_col", ref_idct(pack_in(a), 18), pack_out(e));

      // Saturation both ways
      a = '{1 << 20, 0, 0, 0, 0, 0, 0, 0};
      e = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
      directed("sat_pos", pack_in(a), pack_out(e));
      a = '{-(1 << 20), 0, 0, 0, 0, 0, 0, 0};
      e = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
      directed("sat_neg", pack_in(a), pack_out(e));

      // Backpressure: 10 back-to-back vectors, ready_in low for cycles 3..8
      for (int i = 0; i < 10; i++) bp[i] = rnd_vec();
      sent = 0;
      nout = 0;
      for (int i = 0; i < 60; i++) begin
         if (sent >= 10 && q.size() == 0) break;
         valid_in = (sent < 10);
         if (sent < 10) idct_in = bp[sent];
         ready_in = !(i >= 3 && i <= 8);
         tick();
         if (out_fire) nout++;
         if (last_acc) sent++;
         if (i == 2) chk("bp_ready_out_open", obs_ro, 1);
         if (i == 8) chk("bp_ready_out_stalled", obs_ro, 0);
      end
      valid_in = 1'b0;
      ready_in = 1'b1;
      chk("bp_in_count", sent, 10);
      chk("bp_out_count", nout, 10);

      // Reset with three vectors in flight
      for (int i = 0; i < 3; i++) begin
         valid_in = 1'b1;
         idct_in  = rnd_vec();
         tick();
      end
      valid_in = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("rst_mid_valid_out", obs_vo, 0);
      chkv("rst_mid_idct_out_row", obs_out_a, '0);
      chkv("rst_mid_idct_out_col", obs_out_b, '0);
      nvo = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (obs_vo) nvo++;
      end
      chk("rst_mid_no_stale", nvo, 0);

      // Random traffic with random backpressure
      sent = 0;
      c = 0;
      while (sent < 5000 && c < 40000) begin
         if (!valid_in && $urandom_range(0, 4) != 0) begin
            valid_in = 1'b1;
            idct_in  = rnd_vec();
         end
         ready_in = ($urandom_range(0, 9) < 7);
         tick();
         c++;
         if (last_acc) begin
            sent++;
            valid_in = 1'b0;
         end
      end
      chk("rand_in_count", sent, 5000);
      valid_in = 1'b0;
      ready_in = 1'b1;
      c = 0;
      while (q.size() > 0 && c < 20) begin
         tick();
         c++;
      end
      chk("drain_empty", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
